// File: rtl/adder_operand_stage.sv
// Operand register stage for the clock-gated 16-bit adder.
// Registers operand triples and drives the adder clock enable from operand activity.
module adder_operand_stage #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned IDLE_CYCLES = 8,
    parameter int unsigned WAKE_CYCLES = 2,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_carry,
    input  logic             cg_disable,
    output logic [WIDTH-1:0] a_in,
    output logic [WIDTH-1:0] b_in,
    output logic             carry_in,
    output logic             CG,
    output logic [CNT_W-1:0] gated_cycles
);

    localparam int unsigned IW = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
    localparam int unsigned WW = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);
    localparam logic [WW-1:0] WAKE_LAST = WW'(WAKE_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        GATED = 2'd1,
        WAKE  = 2'd2
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic             cg_q;
    logic [IW-1:0]    idle_q;
    logic [WW-1:0]    wake_q;
    logic [CNT_W-1:0] gated_q;

    logic             xfer;
    logic             change;
    logic             wake_req;

    assign xfer     = (state_q == RUN) && in_valid;
    assign change   = xfer && ({in_a, in_b, in_carry} != {a_q, b_q, carry_q});
    assign wake_req = in_valid || cg_disable;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cg_q    <= 1'b1;
            idle_q  <= '0;
            wake_q  <= '0;
            gated_q <= '0;
        end else begin
            if (!cg_q && (gated_q != '1)) begin
                gated_q <= gated_q + CNT_W'(1);
            end
            unique case (state_q)
                RUN: begin
                    if (change) begin
                        a_q     <= in_a;
                        b_q     <= in_b;
                        carry_q <= in_carry;
                        idle_q  <= '0;
                    end else if (!cg_disable) begin
                        // identical transfers and empty edges both count as idle
                        if (idle_q == IDLE_LAST) begin
                            state_q <= GATED;
                            cg_q    <= 1'b0;
                            idle_q  <= '0;
                        end else begin
                            idle_q <= idle_q + IW'(1);
                        end
                    end
                end
                GATED: begin
                    if (wake_req) begin
                        state_q <= WAKE;
                        cg_q    <= 1'b1;
                        wake_q  <= '0;
                    end
                end
                WAKE: begin
                    wake_q <= wake_q + WW'(1);
                    if (wake_q == WAKE_LAST) begin
                        state_q <= RUN;
                        idle_q  <= '0;
                    end
                end
                default: begin
                    state_q <= RUN;
                    cg_q    <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready     = (state_q == RUN);
    assign a_in         = a_q;
    assign b_in         = b_q;
    assign carry_in     = carry_q;
    assign CG           = cg_q;
    assign gated_cycles = gated_q;

endmodule

// File: tb/tb_adder_operand_stage.sv
// Bench for adder_operand_stage: directed scenarios plus randomized traffic
// against a cycle-level model of the gating rules.
module tb_adder_operand_stage;

    localparam int IDLE = 8;
    localparam int WAKE = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        in_carry = 1'b0;
    logic        cg_disable = 1'b0;

    logic        in_ready, carry_in, CG;
    logic [15:0] a_in, b_in;
    logic [31:0] gc;
    logic        r4, c4, cg4;
    logic [15:0] a4, b4;
    logic [3:0]  gc4;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    adder_operand_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_carry(in_carry), .cg_disable(cg_disable),
        .a_in(a_in), .b_in(b_in), .carry_in(carry_in), .CG(CG),
        .gated_cycles(gc)
    );

    adder_operand_stage #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(r4),
        .in_a(in_a), .in_b(in_b), .in_carry(in_carry), .cg_disable(cg_disable),
        .a_in(a4), .b_in(b4), .carry_in(c4), .CG(cg4),
        .gated_cycles(gc4)
    );

    // Reference model: counts quiet edges since the last real operand change
    typedef enum {M_RUN, M_GATED, M_WAKE} mphase_t;
    mphase_t     m_phase = M_RUN;
    logic [15:0] m_a = '0, m_b = '0;
    logic        m_c = 1'b0, m_cg = 1'b1;
    int          m_quiet = 0, m_wake_left = 0;
    longint      m_gated = 0;
    bit          m_xfer = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase = M_RUN; m_a = '0; m_b = '0; m_c = 1'b0; m_cg = 1'b1;
            m_quiet = 0; m_wake_left = 0; m_gated = 0; m_xfer = 0;
        end else begin
            m_xfer = 0;
            if (!m_cg) m_gated++;
            case (m_phase)
                M_RUN: begin
                    m_xfer = in_valid;
                    if (in_valid && (in_a != m_a || in_b != m_b || in_carry != m_c)) begin
                        m_a = in_a; m_b = in_b; m_c = in_carry; m_quiet = 0;
                    end else if (!cg_disable) begin
                        m_quiet++;
                        if (m_quiet == IDLE) begin
                            m_phase = M_GATED; m_cg = 1'b0; m_quiet = 0;
                        end
                    end
                end
                M_GATED: if (in_valid || cg_disable) begin
                    m_phase = M_WAKE; m_cg = 1'b1; m_wake_left = WAKE;
                end
                default: begin
                    m_wake_left--;
                    if (m_wake_left == 0) begin
                        m_phase = M_RUN; m_quiet = 0;
                    end
                end
            endcase
        end
    end

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        #2;
        nvec++;
        if ({a_in, b_in, carry_in, CG, in_ready, gc, gc4} !== {32'h0, 1'b0, 1'b1, 1'b1, 32'h0, 4'h0}) begin
            nerr++;
            $display("FAIL reset_values got a=%h b=%h c=%b cg=%b rdy=%b gc=%0d gc4=%0d want 0/0/0/1/1/0/0",
                     a_in, b_in, carry_in, CG, in_ready, gc, gc4);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_transfer();
        in_valid = 1'b1; in_a = 16'hA5A5; in_b = 16'h5A5A; in_carry = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        nvec++;
        if ({a_in, b_in, carry_in, CG, gc} !== {16'hA5A5, 16'h5A5A, 1'b0, 1'b1, 32'h0}) begin
            nerr++;
            $display("FAIL transfer got a=%h b=%h c=%b cg=%b gc=%0d want A5A5/5A5A/0/1/0",
                     a_in, b_in, carry_in, CG, gc);
        end
    endtask

    task automatic test_gating();
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            nvec++;
            if ({CG, in_ready} !== {k < IDLE, k < IDLE} || gc !== 32'((k > IDLE) ? k - IDLE : 0)) begin
                nerr++;
                $display("FAIL gating k=%0d got cg=%b rdy=%b gc=%0d want cg=%b gc=%0d",
                         k, CG, in_ready, gc, k < IDLE, (k > IDLE) ? k - IDLE : 0);
            end
        end
    endtask

    task automatic test_wake();
        in_valid = 1'b1; in_a = 16'h1707; in_b = 16'h2345; in_carry = 1'b0;
        @(negedge clk);
        nvec++;
        if ({CG, in_ready} !== 2'b10) begin
            nerr++;
            $display("FAIL wake_cg got cg=%b rdy=%b want 1/0", CG, in_ready);
        end
        @(negedge clk);
        nvec++;
        if (in_ready !== 1'b0) begin
            nerr++;
            $display("FAIL wake_hold got rdy=%b want 0", in_ready);
        end
        @(negedge clk);
        nvec++;
        if ({in_ready, a_in} !== {1'b1, 16'hA5A5}) begin
            nerr++;
            $display("FAIL wake_ready got rdy=%b a=%h want 1/A5A5", in_ready, a_in);
        end
        @(negedge clk);
        in_valid = 1'b0;
        nvec++;
        if ({a_in, b_in} !== {16'h1707, 16'h2345}) begin
            nerr++;
            $display("FAIL wake_xfer got a=%h b=%h want 1707/2345", a_in, b_in);
        end
    endtask

    task automatic test_identical();
        in_valid = 1'b1; in_a = 16'h3C3C; in_b = 16'h00FF; in_carry = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= IDLE; k++) begin
            @(negedge clk);
            nvec++;
            if ({CG, a_in, carry_in} !== {k < IDLE, 16'h3C3C, 1'b1}) begin
                nerr++;
                $display("FAIL identical k=%0d got cg=%b a=%h want cg=%b a=3C3C", k, CG, a_in, k < IDLE);
            end
        end
        in_valid = 1'b0;
        in_valid = 1'b1; in_a = 16'h1111; in_b = 16'h2222; in_carry = 1'b0;
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        repeat (IDLE - 1) @(negedge clk);
        in_valid = 1'b1; in_a = 16'h4444; in_b = 16'h5555; in_carry = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        nvec++;
        if ({CG, in_ready, a_in, b_in} !== {1'b1, 1'b1, 16'h4444, 16'h5555}) begin
            nerr++;
            $display("FAIL change_at_threshold got cg=%b rdy=%b a=%h b=%h want 1/1/4444/5555",
                     CG, in_ready, a_in, b_in);
        end
        for (int k = 1; k <= IDLE; k++) begin
            @(negedge clk);
            nvec++;
            if (CG !== (k < IDLE)) begin
                nerr++;
                $display("FAIL regate k=%0d got cg=%b want %b", k, CG, k < IDLE);
            end
        end
    endtask

    task automatic test_cg_disable();
        int n;
        cg_disable = 1'b1;
        @(negedge clk);
        nvec++;
        if ({CG, in_ready} !== 2'b10) begin
            nerr++;
            $display("FAIL dis_wake got cg=%b rdy=%b want 1/0", CG, in_ready);
        end
        repeat (2) @(negedge clk);
        nvec++;
        if (in_ready !== 1'b1) begin
            nerr++;
            $display("FAIL dis_ready got rdy=%b want 1", in_ready);
        end
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            nvec++;
            if (CG !== 1'b1) begin
                nerr++;
                $display("FAIL dis_hold k=%0d got cg=%b want 1", k, CG);
            end
        end
        cg_disable = 1'b0;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (CG === 1'b0) break;
        end
        nvec++;
        if (n != IDLE) begin
            nerr++;
            $display("FAIL dis_release got %0d edges to gate want %0d", n, IDLE);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        in_valid = 1'b1; in_a = 16'h0F0F; in_b = 16'hF0F0; in_carry = 1'b1;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        nvec++;
        if ({a_in, b_in, carry_in, CG, in_ready, gc} !== {32'h0, 1'b0, 1'b1, 1'b1, 32'h0}) begin
            nerr++;
            $display("FAIL reset_wake got a=%h cg=%b rdy=%b gc=%0d want 0/1/1/0", a_in, CG, in_ready, gc);
        end
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b0;
        n = 0;
        while (n < 30 && CG !== 1'b0) begin
            @(negedge clk);
            n++;
        end
        nvec++;
        if (CG !== 1'b0) begin
            nerr++;
            $display("FAIL reset_gate_timeout got cg=%b want 0", CG);
        end
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        nvec++;
        if ({CG, in_ready, gc, gc4} !== {1'b1, 1'b1, 32'h0, 4'h0}) begin
            nerr++;
            $display("FAIL reset_gated got cg=%b rdy=%b gc=%0d gc4=%0d want 1/1/0/0", CG, in_ready, gc, gc4);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_saturate();
        for (int k = 1; k <= IDLE + 20; k++) begin
            @(negedge clk);
            nvec++;
            if (cg4 !== (k < IDLE) || gc4 !== 4'((k - IDLE > 15) ? 15 : ((k > IDLE) ? k - IDLE : 0))) begin
                nerr++;
                $display("FAIL sat k=%0d got cg=%b gc4=%0d", k, cg4, gc4);
            end
        end
        nvec++;
        if ({gc4, gc} !== {4'hF, 32'd20}) begin
            nerr++;
            $display("FAIL sat_final got gc4=%h gc=%0d want F/20", gc4, gc);
        end
    endtask

    task automatic test_random();
        logic [3:0] e4;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            e4 = (m_gated > 15) ? 4'hF : 4'(m_gated);
            nvec++;
            if ({a_in, b_in, carry_in, CG, in_ready, gc, gc4} !==
                {m_a, m_b, m_c, m_cg, m_phase == M_RUN, m_gated[31:0], e4}) begin
                nerr++;
                $display("FAIL rand k=%0d got a=%h b=%h c=%b cg=%b rdy=%b gc=%0d gc4=%0d want %h %h %b %b %b %0d %0d",
                         k, a_in, b_in, carry_in, CG, in_ready, gc, gc4,
                         m_a, m_b, m_c, m_cg, m_phase == M_RUN, m_gated, e4);
            end
            if (!(in_valid && !m_xfer)) begin
                in_valid = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 2) == 0) begin
                    in_a = 16'($urandom);
                    in_b = 16'($urandom_range(0, 3));
                    in_carry = 1'($urandom);
                end
            end
            if ($urandom_range(0, 24) == 0) cg_disable = ~cg_disable;
        end
        cg_disable = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_transfer();
        test_gating();
        test_wake();
        test_identical();
        test_cg_disable();
        test_reset_mid();
        test_saturate();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
